// File: rtl/spi_sck_gen.sv
// SPI serial-clock generator: programmable half-period, CPOL/CPHA, bounded
// burst of 2*num_bits SCK edges with sample/shift strobes and a CS-hold tail.
module spi_sck_gen #(
  parameter int DIV_W  = 8,
  parameter int BITS_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DIV_W-1:0]  div,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [BITS_W-1:0] num_bits,
  output logic              sck,
  output logic              sample_pulse,
  output logic              shift_pulse,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [BITS_W:0]   edge_q, edge_d, edge_nxt;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [BITS_W-1:0] nbits_q, nbits_d;
  logic              sck_q, sck_d;
  logic              samp_q, samp_d;
  logic              shift_q, shift_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  assign edge_nxt = edge_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    div_d   = div_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    nbits_d = nbits_q;
    sck_d   = sck_q;
    samp_d  = 1'b0;
    shift_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        sck_d  = cpol;
        cnt_d  = '0;
        edge_d = '0;
        if (start && !abort) begin
          if (num_bits == '0) begin
            done_d = 1'b1;
          end else begin
            div_d   = div;
            cpol_d  = cpol;
            cpha_d  = cpha;
            nbits_d = num_bits;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          sck_d   = cpol;
          busy_d  = 1'b0;
          cnt_d   = '0;
          edge_d  = '0;
        end else if (cnt_q == div_q) begin
          cnt_d  = '0;
          edge_d = edge_nxt;
          sck_d  = ~sck_q;
          // Odd edges lead (move away from CPOL); CPHA picks which edge samples.
          samp_d  = edge_nxt[0] ? ~cpha_q : cpha_q;
          shift_d = edge_nxt[0] ? cpha_q : ~cpha_q;
          if (edge_nxt == {nbits_q, 1'b0}) begin
            sck_d   = cpol_q;
            state_d = S_TAIL;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TAIL: begin
        if (abort) begin
          state_d = S_IDLE;
          sck_d   = cpol;
          busy_d  = 1'b0;
          cnt_d   = '0;
          edge_d  = '0;
        end else if (done_q) begin
          // Leave only after the done cycle so a start coinciding with done is dropped.
          state_d = S_IDLE;
          cnt_d   = '0;
          edge_d  = '0;
        end else if (cnt_q == div_q) begin
          cnt_d  = '0;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      div_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      nbits_q <= '0;
      sck_q   <= 1'b0;
      samp_q  <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      div_q   <= div_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      nbits_q <= nbits_d;
      sck_q   <= sck_d;
      samp_q  <= samp_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sck          = sck_q;
  assign sample_pulse = samp_q;
  assign shift_pulse  = shift_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
